// File: rtl/alu_param_seq.sv
// Purpose: handshaked WIDTH/half-width ALU with registered Z|C|N|V flags and iterative shifts/rotates.
// Latency: non-shift ops and zero-amount shifts in 1 cycle; shifts/rotates take exactly shamt cycles.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, so no overlap of ops.
module alu_param_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         fun_sel,
    input  logic [WIDTH-1:0]   input_a,
    input  logic [WIDTH-1:0]   input_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin_load,
    input  logic               cin_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_out,
    output logic [3:0]         flags
);

    localparam int HALF  = WIDTH / 2;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic               wc;
    logic [3:0]         op_q;
    logic               half_q;
    logic               z_q, c_q, n_q, v_q;

    // Sign-extend the active half-width result when operating in half mode.
    function automatic logic [WIDTH-1:0] sext(input logic [WIDTH-1:0] r, input logic half);
        return half ? {{HALF{r[HALF-1]}}, r[HALF-1:0]} : r;
    endfunction

    // One position of shift/rotate within the active width; returns {carry, value}.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] w, input logic c,
                                                  input logic [3:0] op, input logic half);
        logic [WIDTH-1:0] r;
        logic             co;
        logic [IDX_W-1:0] m;
        m  = half ? IDX_W'(HALF - 1) : IDX_W'(WIDTH - 1);
        r  = w;
        co = c;
        case (op)
            4'hB: begin co = w[m]; r = w << 1; end
            4'hC: begin co = w[0]; r = w >> 1; r[m] = 1'b0; end
            4'hD: begin co = w[0]; r = w >> 1; r[m] = w[m]; end
            4'hE: begin co = w[m]; r = {w[WIDTH-2:0], c}; end
            4'hF: begin co = w[0]; r = w >> 1; r[m] = c; end
            default: ;
        endcase
        return {co, r};
    endfunction

    logic [3:0]         op;
    logic               half;
    logic               c_eff;
    logic               is_shift;
    logic [SHAMT_W-1:0] sh_sat;
    logic [WIDTH-1:0]   a_m, b_m, raw, res;
    logic [WIDTH:0]     sum;
    logic [IDX_W-1:0]   m_in;
    logic               c_new, v_new;
    logic [WIDTH-1:0]   step_w, step_res;
    logic               step_c;

    assign op        = fun_sel[3:0];
    assign half      = ~fun_sel[4];
    assign c_eff     = cin_load ? cin_value : c_q;
    assign is_shift  = (op >= 4'hB);
    assign sh_sat    = (shamt > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt;
    assign in_ready  = (state == IDLE) && reset_n;
    assign flags     = {z_q, c_q, n_q, v_q};
    assign {step_c, step_w} = shift_step(work, wc, op_q, half_q);
    assign step_res  = sext(step_w, half_q);

    // Single-cycle datapath for the request currently presented in IDLE.
    always_comb begin
        a_m   = half ? {{HALF{1'b0}}, input_a[HALF-1:0]} : input_a;
        b_m   = half ? {{HALF{1'b0}}, input_b[HALF-1:0]} : input_b;
        m_in  = half ? IDX_W'(HALF - 1) : IDX_W'(WIDTH - 1);
        sum   = {1'b0, a_m} + {1'b0, b_m} + {{WIDTH{1'b0}}, (op == 4'h5) ? c_eff : 1'b0};
        raw   = a_m;
        c_new = c_eff;
        v_new = 1'b0;
        case (op)
            4'h0: raw = a_m;
            4'h1: raw = b_m;
            4'h2: raw = ~a_m;
            4'h3: raw = ~b_m;
            4'h4, 4'h5: begin
                raw   = sum[WIDTH-1:0];
                c_new = half ? sum[HALF] : sum[WIDTH];
                v_new = (a_m[m_in] == b_m[m_in]) && (raw[m_in] != a_m[m_in]);
            end
            4'h6: begin
                raw   = a_m - b_m;
                c_new = (a_m >= b_m);
                v_new = (a_m[m_in] != b_m[m_in]) && (raw[m_in] != a_m[m_in]);
            end
            4'h7: raw = a_m & b_m;
            4'h8: raw = a_m | b_m;
            4'h9: raw = a_m ^ b_m;
            4'hA: raw = ~(a_m & b_m);
            default: raw = a_m;
        endcase
        res = sext(raw, half);
    end

    // Control FSM: accept in IDLE, iterate shifts in SHIFT, present result in HOLD.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            alu_out   <= '0;
            out_valid <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            wc        <= 1'b0;
            op_q      <= '0;
            half_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cin_load) c_q <= cin_value;
                    if (in_valid) begin
                        if (is_shift && (sh_sat != '0)) begin
                            work   <= a_m;
                            cnt    <= sh_sat;
                            wc     <= c_eff;
                            op_q   <= op;
                            half_q <= half;
                            state  <= SHIFT;
                        end else begin
                            alu_out   <= res;
                            z_q       <= (res == '0);
                            c_q       <= c_new;
                            n_q       <= res[WIDTH-1];
                            v_q       <= v_new;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_w;
                    wc   <= step_c;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        alu_out   <= step_res;
                        z_q       <= (step_res == '0);
                        c_q       <= step_c;
                        n_q       <= step_res[WIDTH-1];
                        v_q       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_param_seq.sv
// Purpose: directed bench for alu_param_seq (WIDTH = 32) with an expected-result queue.
// Latency: checks cycles from accept to out_valid for every transaction.
// Backpressure: exercises HOLD stalls, handshake ordering and reset abort mid-shift.
module tb_alu_param_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [4:0]  fun_sel;
    logic [31:0] input_a, input_b;
    logic [5:0]  shamt;
    logic        cin_load, cin_value;
    logic        out_valid, out_ready;
    logic [31:0] alu_out;
    logic [3:0]  flags;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic model_c = 1'b0;

    alu_param_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fun_sel(fun_sel), .input_a(input_a), .input_b(input_b), .shamt(shamt),
        .cin_load(cin_load), .cin_value(cin_value), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .flags(flags)
    );

    always #5 clock = ~clock;

    `define CHK(tag, obs, exp) begin \
        n_chk++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp); \
        end \
    end

    // Reference model of one transaction, worked in 64-bit arithmetic.
    task automatic model_op(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                            input int sh, input logic c_in, output exp_t e, output logic c_out);
        int          aw;
        int          n;
        logic [63:0] mask, am, bm, r;
        logic        c, v, nc, s;
        logic [31:0] res;
        aw   = fun[4] ? 32 : 16;
        mask = (64'd1 << aw) - 64'd1;
        am   = {32'd0, a} & mask;
        bm   = {32'd0, b} & mask;
        c    = c_in;
        v    = 1'b0;
        r    = am;
        n    = (sh > 32) ? 32 : sh;
        case (fun[3:0])
            4'h0: r = am;
            4'h1: r = bm;
            4'h2: r = ~am & mask;
            4'h3: r = ~bm & mask;
            4'h4, 4'h5: begin
                r = am + bm + ((fun[3:0] == 4'h5) ? {63'd0, c_in} : 64'd0);
                c = r[aw];
                r = r & mask;
                v = (am[aw-1] == bm[aw-1]) && (r[aw-1] != am[aw-1]);
            end
            4'h6: begin
                r = (am - bm) & mask;
                c = (am >= bm);
                v = (am[aw-1] != bm[aw-1]) && (r[aw-1] != am[aw-1]);
            end
            4'h7: r = am & bm;
            4'h8: r = am | bm;
            4'h9: r = am ^ bm;
            4'hA: r = ~(am & bm) & mask;
            default: begin
                for (int i = 0; i < n; i++) begin
                    case (fun[3:0])
                        4'hB: begin c = r[aw-1]; r = (r << 1) & mask; end
                        4'hC: begin c = r[0]; r = r >> 1; end
                        4'hD: begin c = r[0]; s = r[aw-1]; r = r >> 1;
                                    if (s) r = r | (64'd1 << (aw-1)); end
                        4'hE: begin nc = r[aw-1]; r = ((r << 1) | {63'd0, c}) & mask; c = nc; end
                        default: begin nc = r[0]; r = (r >> 1) | ({63'd0, c} << (aw-1)); c = nc; end
                    endcase
                end
            end
        endcase
        res = r[31:0];
        if (!fun[4] && r[15]) res[31:16] = 16'hFFFF;
        e.res = res;
        e.flg = {(res == 32'd0), c, res[31], v};
        e.lat = (fun[3:0] >= 4'hB && sh != 0) ? n : 0;
        c_out = c;
    endtask

    // Present a request, push its expectation, and complete the accept edge.
    task automatic issue(input logic [4:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input int sh, input logic cl, input logic cv,
                         input bit use_lit, input logic [31:0] lr, input logic [3:0] lf, input int ll);
        exp_t e;
        logic cn;
        @(negedge clock);
        fun_sel = fun; input_a = a; input_b = b; shamt = 6'(sh);
        cin_load = cl; cin_value = cv; in_valid = 1'b1;
        model_op(fun, a, b, sh, cl ? cv : model_c, e, cn);
        model_c = cn;
        if (use_lit) begin e.res = lr; e.flg = lf; e.lat = ll; end
        sb.push_back(e);
        `CHK("in_ready_idle", in_ready, 1'b1)
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        cin_load = 1'b0;
    endtask

    // Wait (bounded) for the result, then compare latency, value and flags.
    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_chk++;
        if (!out_valid) begin
            n_fail++;
            $error("FAIL %s_timeout: out_valid not seen within %0d cycles", tag, lat);
        end
        e = sb.pop_front();
        `CHK({tag, "_lat"}, lat, e.lat)
        `CHK({tag, "_res"}, alu_out, e.res)
        `CHK({tag, "_flags"}, flags, e.flg)
    endtask

    task automatic handshake();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [4:0] fun, input logic [31:0] a,
                       input logic [31:0] b, input int sh);
        issue(fun, a, b, sh, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 0);
        wait_result(tag);
        handshake();
    endtask

    initial begin
        logic [31:0] hold_res;
        logic [3:0]  hold_flg;
        bit          seen;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fun_sel = '0;
        input_a = '0; input_b = '0; shamt = '0; cin_load = 1'b0; cin_value = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || alu_out !== 32'd0 || flags !== 4'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $error("FAIL rst_state: out_valid=%b alu_out=%h flags=%b in_ready=%b",
                   out_valid, alu_out, flags, in_ready);
        end
        `CHK("rst_out_valid", out_valid, 1'b0)
        `CHK("rst_alu_out", alu_out, 32'd0)
        `CHK("rst_flags", flags, 4'd0)
        `CHK("rst_in_ready", in_ready, 1'b0)
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors with literal expectations.
        issue(5'b10100, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 1'b0, 1'b1, 32'h00000000, 4'b1100, 0);
        wait_result("add_full_wrap");
        handshake();
        issue(5'b00110, 32'h00000005, 32'h00000007, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 4'b0010, 0);
        wait_result("sub_half");
        handshake();
        issue(5'b11011, 32'h10000001, 32'h0, 4, 1'b0, 1'b0, 1'b1, 32'h00000010, 4'b0100, 4);
        wait_result("lsl4");
        handshake();
        issue(5'b10101, 32'h1, 32'h1, 0, 1'b1, 1'b1, 1'b1, 32'h00000003, 4'b0000, 0);
        wait_result("adc_cin_load");

        // HOLD stall: result stable, no accept until handshake.
        hold_res = alu_out;
        hold_flg = flags;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            fun_sel = 5'b10001; input_b = 32'hA5A5A5A5; in_valid = 1'b1;
            `CHK("hold_in_ready", in_ready, 1'b0)
            @(posedge clock);
            #1;
            `CHK("hold_valid", out_valid, 1'b1)
            `CHK("hold_res", alu_out, hold_res)
            `CHK("hold_flags", flags, hold_flg)
        end
        handshake();
        `CHK("post_hs_valid", out_valid, 1'b0)
        `CHK("post_hs_ready", in_ready, 1'b1)
        issue(5'b10001, 32'h0, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 0);
        wait_result("pass_b");
        handshake();

        // Model-checked coverage of the remaining ops and shift boundaries.
        run("pass_a",     5'b10000, 32'h12345678, 32'h0, 0);
        run("not_b_half", 5'b00011, 32'h0, 32'h00008001, 0);
        run("not_a",      5'b10010, 32'h0F0F0000, 32'h0, 0);
        run("and",        5'b10111, 32'hF0F0FFFF, 32'h0FF0F00F, 0);
        run("or",         5'b11000, 32'hF0000000, 32'h0000000F, 0);
        run("xor",        5'b11001, 32'hFFFF0000, 32'hFF00FF00, 0);
        run("nand",       5'b11010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run("sub_eq",     5'b10110, 32'h00000003, 32'h00000003, 0);
        run("sub_ovf",    5'b10110, 32'h80000000, 32'h00000001, 0);
        run("add_h_ovf",  5'b00100, 32'hABCD7FFF, 32'h00000001, 0);
        run("adc_chain",  5'b10101, 32'h7FFFFFFF, 32'h00000000, 0);
        run("asr_half",   5'b01101, 32'h00008010, 32'h0, 3);
        run("csl_half",   5'b01110, 32'h0000C001, 32'h0, 17);
        run("lsr_sat",    5'b11100, 32'h80000000, 32'h0, 40);
        run("csr_zero",   5'b11111, 32'h87654321, 32'h0, 0);
        run("asr_full",   5'b11101, 32'h80000003, 32'h0, 1);
        run("csr_full",   5'b11111, 32'h00000001, 32'h0, 33);

        // Reset during the third SHIFT cycle aborts the rotate.
        @(negedge clock);
        fun_sel = 5'b11111; input_a = 32'hDEADBEEF; shamt = 6'd20; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        `CHK("abort_valid", out_valid, 1'b0)
        `CHK("abort_flags", flags, 4'd0)
        `CHK("abort_ready_low", in_ready, 1'b0)
        @(negedge clock);
        reset_n = 1'b1;
        model_c = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            seen = seen | out_valid;
        end
        `CHK("abort_no_stale", seen, 1'b0)
        `CHK("abort_idle", in_ready, 1'b1)
        run("after_abort", 5'b11110, 32'h80000001, 32'h0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
